vga_timing_gen: RTL and testbench

- Consumes the 25.175 MHz pixel clock and the lock flag from the VGA PLL, and generates 640x480@60 raster timing: hsync, vsync, data-enable, pixel coordinates and frame/line strobes.
- Output is held blanked until PLL lock is synchronized and stable; timing restarts cleanly on loss of lock.
- Sits between the clock block and the PPU/framebuffer scan-out logic.

---
 rtl/vga_timing_pkg.sv | 39 +++
 rtl/sync_2ff.sv | 27 ++
 rtl/vga_timing_gen.sv | 185 ++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, FSM state encoding and colour-bar table
// for the VGA raster generator.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE      = 640;
  localparam int unsigned H_FP          = 16;
  localparam int unsigned H_SYNC        = 96;
  localparam int unsigned H_BP          = 48;
  localparam int unsigned V_ACTIVE      = 480;
  localparam int unsigned V_FP          = 10;
  localparam int unsigned V_SYNC        = 2;
  localparam int unsigned V_BP          = 33;
  localparam int unsigned H_TOTAL       = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL       = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam bit          SYNC_POL      = 1'b0;
  localparam int unsigned SETTLE_CYCLES = 1024;

  localparam int unsigned H_CNT_W   = 10;
  localparam int unsigned V_CNT_W   = 10;
  localparam int unsigned X_W       = 10;
  localparam int unsigned Y_W       = 9;
  localparam int unsigned RGB_W     = 24;
  localparam int unsigned BAR_W     = 80;
  localparam int unsigned N_BARS    = 8;
  localparam int unsigned BAR_IDX_W = 3;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_e;

  // Index 0 is the left-most bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [N_BARS-1:0][RGB_W-1:0] BAR_RGB = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level signal into the clk domain.
module sync_2ff #(
  parameter int unsigned      WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator gated by a qualified PLL lock.
// Optional colour-bar output on rgb when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACT_PX    = H_ACTIVE,
  parameter int unsigned H_FP_PX     = H_FP,
  parameter int unsigned H_SYNC_PX   = H_SYNC,
  parameter int unsigned H_BP_PX     = H_BP,
  parameter int unsigned V_ACT_LN    = V_ACTIVE,
  parameter int unsigned V_FP_LN     = V_FP,
  parameter int unsigned V_SYNC_LN   = V_SYNC,
  parameter int unsigned V_BP_LN     = V_BP,
  parameter bit          SYNC_LEVEL  = SYNC_POL,
  parameter int unsigned SETTLE_CLKS = SETTLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             enable,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic             line_start,
  output logic             frame_start,
  output logic             running,
  output logic [RGB_W-1:0] rgb
);

  localparam int unsigned H_PERIOD = H_ACT_PX + H_FP_PX + H_SYNC_PX + H_BP_PX;
  localparam int unsigned V_PERIOD = V_ACT_LN + V_FP_LN + V_SYNC_LN + V_BP_LN;
  localparam int unsigned SET_W    = (SETTLE_CLKS > 1) ? $clog2(SETTLE_CLKS) : 1;

  localparam logic [H_CNT_W-1:0] H_LAST   = H_CNT_W'(H_PERIOD - 1);
  localparam logic [H_CNT_W-1:0] H_VIS    = H_CNT_W'(H_ACT_PX);
  localparam logic [H_CNT_W-1:0] HS_FIRST = H_CNT_W'(H_ACT_PX + H_FP_PX);
  localparam logic [H_CNT_W-1:0] HS_LAST  = H_CNT_W'(H_ACT_PX + H_FP_PX + H_SYNC_PX - 1);
  localparam logic [V_CNT_W-1:0] V_LAST   = V_CNT_W'(V_PERIOD - 1);
  localparam logic [V_CNT_W-1:0] V_VIS    = V_CNT_W'(V_ACT_LN);
  localparam logic [V_CNT_W-1:0] VS_FIRST = V_CNT_W'(V_ACT_LN + V_FP_LN);
  localparam logic [V_CNT_W-1:0] VS_LAST  = V_CNT_W'(V_ACT_LN + V_FP_LN + V_SYNC_LN - 1);
  localparam logic [SET_W-1:0]   SET_LAST = SET_W'(SETTLE_CLKS - 1);

  logic               lock_s;
  logic               go;
  state_e             state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [H_CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [V_CNT_W-1:0] v_cnt_q, v_cnt_d;

  logic               out_ok;
  logic               hsync_d, hsync_q;
  logic               vsync_d, vsync_q;
  logic               de_d, de_q;
  logic [X_W-1:0]     x_d, x_q;
  logic [Y_W-1:0]     y_d, y_q;
  logic               line_start_d, line_start_q;
  logic               frame_start_d, frame_start_q;
  logic               running_d, running_q;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b0)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_locked),
    .q_o   (lock_s)
  );

  assign go = lock_s && enable;

  // Lock qualification and raster counters; counters are held at zero outside RUN.
  always_comb begin : fsm_next
    state_d  = state_q;
    settle_d = '0;
    h_cnt_d  = '0;
    v_cnt_d  = '0;
    case (state_q)
      WAIT_LOCK: begin
        if (go) state_d = SETTLE;
      end
      SETTLE: begin
        if (!go)                        state_d = WAIT_LOCK;
        else if (settle_q == SET_LAST)  state_d = RUN;
        else                            settle_d = settle_q + 1'b1;
      end
      RUN: begin
        if (!go) begin
          state_d = WAIT_LOCK;
        end else if (h_cnt_q == H_LAST) begin
          h_cnt_d = '0;
          v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end else begin
          h_cnt_d = h_cnt_q + 1'b1;
          v_cnt_d = v_cnt_q;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT_LOCK;
      settle_q <= '0;
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
    end
  end

  // Decode only when RUN persists, so a loss of lock blanks on the same edge it exits RUN.
  always_comb begin : out_next
    out_ok        = (state_q == RUN) && (state_d == RUN);
    de_d          = out_ok && (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    hsync_d       = (out_ok && (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST)) ?
                    SYNC_LEVEL : ~SYNC_LEVEL;
    vsync_d       = (out_ok && (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST)) ?
                    SYNC_LEVEL : ~SYNC_LEVEL;
    x_d           = de_d ? X_W'(h_cnt_q) : '0;
    y_d           = de_d ? v_cnt_q[Y_W-1:0] : '0;
    line_start_d  = de_d && (h_cnt_q == '0);
    frame_start_d = line_start_d && (v_cnt_q == '0);
    running_d     = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= ~SYNC_LEVEL;
      vsync_q       <= ~SYNC_LEVEL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      running_q     <= running_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign running     = running_q;

`ifdef VGA_TEST_PATTERN_EN
  logic [BAR_IDX_W-1:0] bar_idx;
  logic [RGB_W-1:0]     rgb_d, rgb_q;

  // Colour bars follow the same decode stage as de so they stay pixel-aligned.
  always_comb begin : bar_next
    bar_idx = BAR_IDX_W'(h_cnt_q / H_CNT_W'(BAR_W));
    rgb_d   = de_d ? BAR_RGB[bar_idx] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rgb_q <= '0;
    else        rgb_q <= rgb_d;
  end

  assign rgb = rgb_q;
`else
  assign rgb = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen; the frame is shortened vertically (15 lines)
// so whole frames, vsync and wrap fit in a short run. Horizontal timing is full 800 clks.
module tb_vga_timing_gen;

  localparam int H_TOT   = 800;
  localparam int H_ACT   = 640;
  localparam int HS_BEG  = 656;
  localparam int HS_END  = 751;
  localparam int V_ACT   = 8;
  localparam int V_TOT   = 15;
  localparam int VS_BEG  = 10;
  localparam int VS_END  = 11;
  localparam int SETTLE  = 1024;

  logic        clk;
  logic        rst_n;
  logic        pll_locked;
  logic        enable;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        line_start;
  logic        frame_start;
  logic        running;
  logic [23:0] rgb;

  int tests;
  int fails;

  vga_timing_gen #(
    .V_ACT_LN  (V_ACT),
    .V_FP_LN   (2),
    .V_SYNC_LN (2),
    .V_BP_LN   (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .enable      (enable),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .x           (x),
    .y           (y),
    .line_start  (line_start),
    .frame_start (frame_start),
    .running     (running),
    .rgb         (rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] bar_colour(input int h, input logic vis);
`ifdef VGA_TEST_PATTERN_EN
    if (!vis) return 24'h000000;
    case (h / 80)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
`else
    return (vis && h < 0) ? 24'hFFFFFF : 24'h000000;
`endif
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; pll_locked = 1'b0; enable = 1'b0;
    repeat (3) tick();
    tests++;
    if ({hsync, vsync, de, x, y, line_start, frame_start, running, rgb} !==
        {1'b1, 1'b1, 1'b0, 10'd0, 9'd0, 1'b0, 1'b0, 1'b0, 24'd0}) begin
      fails++;
      $display("FAIL reset_outputs hs=%b vs=%b de=%b x=%0d y=%0d run=%b rgb=%h, want idle", hsync, vsync, de, x, y, running, rgb);
    end
    rst_n = 1'b1;
    repeat (4) tick();
    tests++;
    if (running !== 1'b0 || de !== 1'b0) begin
      fails++;
      $display("FAIL idle_without_lock running=%b de=%b want 0 0", running, de);
    end
  endtask

  task automatic test_lock_qual();
    int early = 0;
    pll_locked = 1'b1; enable = 1'b1;
    for (int i = 1; i <= 2 + SETTLE; i++) begin
      tick();
      if (running !== 1'b0) early++;
    end
    tests++;
    if (early !== 0) begin
      fails++;
      $display("FAIL lock_early running high on %0d cycles, want 0", early);
    end
    tick();
    tests++;
    if (running !== 1'b1 || frame_start !== 1'b0 || de !== 1'b0) begin
      fails++;
      $display("FAIL run_entry running=%b fs=%b de=%b want 1 0 0", running, frame_start, de);
    end
    tick();
    tests++;
    if ({frame_start, line_start, de, x, y} !== {1'b1, 1'b1, 1'b1, 10'd0, 9'd0}) begin
      fails++;
      $display("FAIL first_pixel fs=%b ls=%b de=%b x=%0d y=%0d want 1 1 1 0 0", frame_start, line_start, de, x, y);
    end
    tick();
    tests++;
    if ({frame_start, line_start, de, x} !== {1'b0, 1'b0, 1'b1, 10'd1}) begin
      fails++;
      $display("FAIL second_pixel fs=%b ls=%b de=%b x=%0d want 0 0 1 1", frame_start, line_start, de, x);
    end
  endtask

  // Entry: outputs show (v=0,h=1). Walks every pixel of the frame into (0,0) of the next.
  task automatic test_frame();
    int h, v, ls_cnt, shown;
    logic        e_de;
    logic [48:0] obs, exp;
    ls_cnt = 0; shown = 0;
    for (int p = 2; p <= V_TOT * H_TOT; p++) begin
      tick();
      h = p % H_TOT;
      v = (p / H_TOT) % V_TOT;
      e_de = (h < H_ACT) && (v < V_ACT);
      exp = {!(h >= HS_BEG && h <= HS_END), !(v >= VS_BEG && v <= VS_END), e_de,
             e_de ? 10'(h) : 10'd0, e_de ? 9'(v) : 9'd0,
             e_de && (h == 0), e_de && (h == 0) && (v == 0), 1'b1, bar_colour(h, e_de)};
      obs = {hsync, vsync, de, x, y, line_start, frame_start, running, rgb};
      if (line_start === 1'b1) ls_cnt++;
      tests++;
      if (obs !== exp) begin
        fails++;
        if (shown < 10) begin
          shown++;
          $display("FAIL frame_px v=%0d h=%0d got=%h exp=%h", v, h, obs, exp);
        end
      end
    end
    tests++;
    if (ls_cnt !== V_ACT) begin
      fails++;
      $display("FAIL line_start_count got %0d want %0d", ls_cnt, V_ACT);
    end
  endtask

  // Entry: outputs show (0,0). Lock drops while (5,300) is on the outputs.
  task automatic test_loss_mid_frame();
    repeat (5 * H_TOT + 300) tick();
    tests++;
    if ({de, x, y} !== {1'b1, 10'd300, 9'd5}) begin
      fails++;
      $display("FAIL loss_pre de=%b x=%0d y=%0d want 1 300 5", de, x, y);
    end
    pll_locked = 1'b0;
    tick();
    tick();
    tests++;
    if ({running, de, x} !== {1'b1, 1'b1, 10'd302}) begin
      fails++;
      $display("FAIL loss_latency run=%b de=%b x=%0d want 1 1 302", running, de, x);
    end
    tick();
    tests++;
    if ({hsync, vsync, de, x, y, line_start, frame_start, running} !==
        {1'b1, 1'b1, 1'b0, 10'd0, 9'd0, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL loss_blank hs=%b vs=%b de=%b x=%0d y=%0d run=%b want idle", hsync, vsync, de, x, y, running);
    end
  endtask

  // Entry: outputs show (0,1). enable has no synchronizer, so re-entry is 1024 clks to RUN.
  task automatic test_enable_drop();
    int early = 0;
    repeat (9) tick();
    enable = 1'b0;
    tick();
    tests++;
    if ({running, de, x, line_start} !== {1'b0, 1'b0, 10'd0, 1'b0}) begin
      fails++;
      $display("FAIL enable_drop run=%b de=%b x=%0d want 0 0 0", running, de, x);
    end
    enable = 1'b1;
    for (int i = 1; i <= SETTLE; i++) begin
      tick();
      if (running !== 1'b0) early++;
    end
    tests++;
    if (early !== 0) begin
      fails++;
      $display("FAIL enable_settle_early running high on %0d cycles, want 0", early);
    end
    tick();
    tick();
    tests++;
    if ({running, frame_start, x, y} !== {1'b1, 1'b1, 10'd0, 9'd0}) begin
      fails++;
      $display("FAIL enable_rerun run=%b fs=%b x=%0d y=%0d want 1 1 0 0", running, frame_start, x, y);
    end
  endtask

  task automatic test_async_reset();
    repeat (100) tick();
    tests++;
    if ({de, x} !== {1'b1, 10'd100}) begin
      fails++;
      $display("FAIL async_pre de=%b x=%0d want 1 100", de, x);
    end
    rst_n = 1'b0;
    #2;
    tests++;
    if ({hsync, vsync, de, x, y, line_start, frame_start, running, rgb} !==
        {1'b1, 1'b1, 1'b0, 10'd0, 9'd0, 1'b0, 1'b0, 1'b0, 24'd0}) begin
      fails++;
      $display("FAIL async_reset hs=%b vs=%b de=%b x=%0d run=%b rgb=%h want idle", hsync, vsync, de, x, running, rgb);
    end
  endtask

  // Lock glitch while the settle count is 500: settle restarts, RUN arrives 502 clks later.
  task automatic test_lock_glitch();
    int early = 0;
    rst_n = 1'b0; pll_locked = 1'b0; enable = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    pll_locked = 1'b1;
    for (int i = 1; i <= 1528; i++) begin
      tick();
      if (i == 501) pll_locked = 1'b0;
      if (i == 502) pll_locked = 1'b1;
      if (running !== 1'b0) early++;
    end
    tests++;
    if (early !== 0) begin
      fails++;
      $display("FAIL glitch_early running high on %0d cycles, want 0", early);
    end
    tick();
    tests++;
    if (running !== 1'b1) begin
      fails++;
      $display("FAIL glitch_run running=%b want 1", running);
    end
    tick();
    tests++;
    if ({frame_start, x, y} !== {1'b1, 10'd0, 9'd0}) begin
      fails++;
      $display("FAIL glitch_frame fs=%b x=%0d y=%0d want 1 0 0", frame_start, x, y);
    end
  endtask

  // Entry: outputs show (0,0). Bar boundaries on line 0.
  task automatic test_pattern();
    int cur = 0;
    int pos [6] = '{0, 79, 80, 320, 639, 640};
    for (int k = 0; k < 6; k++) begin
      while (cur < pos[k]) begin
        tick();
        cur++;
      end
      tests++;
      if (rgb !== bar_colour(cur, cur < H_ACT)) begin
        fails++;
        $display("FAIL pattern_x%0d rgb=%h want %h", cur, rgb, bar_colour(cur, cur < H_ACT));
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_lock_qual();
    test_frame();
    test_loss_mid_frame();
    test_lock_qual();
    test_enable_drop();
    test_async_reset();
    test_lock_glitch();
    test_pattern();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
